// File: rtl/dyt_sram_ctrl.sv
// Single-port SRAM controller with a valid/ready request port and a
// fixed-latency response port.
//
// Ports:
//   clk, rst     clock (rising edge) and synchronous active-high reset
//   req_valid    request present
//   req_ready    controller accepts a request this cycle (only in RUN)
//   req_wen      1 = write, 0 = read
//   req_addr     32-bit word index; values >= DEPTH are rejected with an error
//   req_wdata    write data
//   req_be       byte write enables, bit i covers bits [8i+7:8i]
//   rsp_valid    one-cycle pulse per accepted request, READ_LATENCY cycles later
//   rsp_rdata    read data; 0 for writes, errors and idle cycles
//   rsp_err      out-of-range address, qualified by rsp_valid
//   init_done    array clear finished, requests are now accepted
module dyt_sram_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEPTH          = 64,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned CLEAR_ON_RESET = 1,
  localparam int unsigned ADDR_WIDTH    = $clog2(DEPTH),
  localparam int unsigned BE_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BE_WIDTH-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] ClrLast = ADDR_WIDTH'(DEPTH - 1);

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  addr_ok;
  logic [ADDR_WIDTH-1:0] mem_idx;

  logic                  s1_valid_q;
  logic                  s1_err_q;
  logic [DATA_WIDTH-1:0] s1_rdata_q;

  // ---------------------------------------------------------------------------
  // Init / run control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == StInit) begin
      if (CLEAR_ON_RESET != 0) begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ClrLast) begin
          state_d = StRun;
        end
      end else begin
        state_d = StRun;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StInit;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign req_ready = (state_q == StRun);
  assign init_done = (state_q == StRun);

  assign accept  = req_valid && req_ready;
  // Full 32-bit compare so out-of-range indices never alias onto real words.
  assign addr_ok = (req_addr < 32'(DEPTH));
  assign mem_idx = req_addr[ADDR_WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Storage: clear port during INIT, byte-masked writes during RUN
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if ((state_q == StInit) && (CLEAR_ON_RESET != 0)) begin
        mem[clr_cnt_q] <= '0;
      end else if (accept && req_wen && addr_ok) begin
        for (int i = 0; i < int'(BE_WIDTH); i++) begin
          if (req_be[i]) begin
            mem[mem_idx][8*i +: 8] <= req_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline; idle slots carry zeros so outputs never hold stale data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_rdata_q <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_err_q   <= accept && !addr_ok;
      s1_rdata_q <= (accept && !req_wen && addr_ok) ? mem[mem_idx] : '0;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_valid_q;
    logic                  s2_err_q;
    logic [DATA_WIDTH-1:0] s2_rdata_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_err_q   <= 1'b0;
        s2_rdata_q <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_err_q   <= s1_err_q;
        s2_rdata_q <= s1_rdata_q;
      end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_err   = s2_err_q;
    assign rsp_rdata = s2_rdata_q;
  end else begin : g_lat1
    assign rsp_valid = s1_valid_q;
    assign rsp_err   = s1_err_q;
    assign rsp_rdata = s1_rdata_q;
  end

endmodule
